mem_stage_pipe: RTL and testbench
=================================

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 256, data memory size in XLEN-bit words; power of two.
REQ-003 Parameter WAIT_CYCLES, default 0, extra cycles per load/store access; legal range 0..15.
REQ-004 Port list, one per line (name, direction, width, meaning); clock and reset come first.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EX/MEM register holds a valid instruction.
- in_ready  out  1  stage accepts the EX/MEM contents this cycle.
- addr_exmem  in  XLEN  ALU result / memory address.
- wdata_exmem  in  XLEN  store data.
- rd_exmem  in  5  destination register.
- funct3_exmem  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU, 011 D (XLEN=64 only).
- branch_exmem, zero_exmem, memread_exmem, memwrite_exmem, mem2reg_exmem, regwrite_exmem  in  1 each  control bits.
- flush  in  1  kill the instruction in the stage.
- pcsrc  out  1  branch taken.
- memdata_memwb, addr_memwb  out  XLEN  MEM/WB load data and ALU result.
- rd_memwb  out  5  MEM/WB destination register.
- mem2reg_memwb, regwrite_memwb, valid_memwb  out  1 each  MEM/WB control bits.
- misalign_memwb  out  1  misaligned access flag (MEM_MISALIGN_TRAP_EN only).

Function
REQ-005 pcsrc SHALL equal branch_exmem & zero_exmem & in_valid & ~flush, combinationally.
REQ-006 FSM states SHALL be IDLE and WAIT; an access is in_valid & (memread_exmem | memwrite_exmem).
REQ-007 In IDLE, a non-memory instruction or an access with WAIT_CYCLES=0 SHALL complete in the same cycle: in_ready=1, MEM/WB loads on the next edge.
REQ-008 In IDLE with WAIT_CYCLES>0, an access SHALL move the FSM to WAIT, load the counter with WAIT_CYCLES, and drive in_ready=0.
REQ-009 In WAIT, the counter SHALL decrement each cycle; when it reaches 1, in_ready=1, the access completes, and the FSM returns to IDLE.
REQ-010 While in_ready=0, the MEM/WB register SHALL load a bubble (valid_memwb=0, regwrite_memwb=0), and the EX/MEM inputs SHALL be held stable by the upstream stage.
REQ-011 Memory writes SHALL occur only on the completion cycle, with byte lanes selected by funct3 and addr[1:0] (addr[2:0] for XLEN=64), little-endian.
REQ-012 Word index SHALL be addr[log2(DEPTH)+log2(XLEN/8)-1 : log2(XLEN/8)]; upper address bits are ignored, so addresses wrap modulo DEPTH.
REQ-013 Loads SHALL read asynchronously, shift the selected lane to bit 0, then sign-extend (B/H/W) or zero-extend (BU/HU) to XLEN.
REQ-014 Non-load instructions SHALL set memdata_memwb to 0.
REQ-015 When flush=1, the stage SHALL suppress the write, return the FSM to IDLE, clear the counter, drive in_ready=1, and load a bubble into MEM/WB.
REQ-016 Simultaneous flush and completion: flush wins, and no write occurs.
REQ-017 An unused funct3 code SHALL be treated as W, with no error.

Reset
REQ-018 When rst_n is low, all MEM/WB outputs SHALL be 0, the FSM SHALL be in IDLE, and the counter SHALL be 0; memory contents SHALL be cleared to 0.
REQ-019 Reset during WAIT SHALL abandon the access with no write.

Configuration
REQ-020 With MEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL:
- suppress the store;
- return 0 for a load;
- clear regwrite_memwb;
- set misalign_memwb=1 for one MEM/WB cycle;
- take no wait states.
REQ-021 An access is misaligned for H with addr[0]=1, for W with addr[1:0]≠0, and for D with addr[2:0]≠0.
REQ-022 Without MEM_MISALIGN_TRAP_EN, misalign_memwb SHALL be absent, and the low address bits below the access size SHALL be forced to 0.

Structure
REQ-023 funct3 encodings, FSM state enum and lane-select helpers SHALL live in the shared package riscv_pkg.
REQ-024 Storage SHALL be one sub-module, data_memory_bytelane (byte-enable write, asynchronous read, DEPTH/XLEN parameters).

Verification
REQ-025 SW 0xDEADBEEF to 0x10, then LW 0x10: memdata_memwb=0xDEADBEEF.
REQ-026 SB 0x80 to 0x13, then LB 0x13 gives 0xFFFFFF80, and LBU 0x13 gives 0x00000080; LW 0x10 gives 0x80ADBEEF.
REQ-027 WAIT_CYCLES=3, LW: in_ready low for exactly 3 cycles, valid_memwb is 0 for those 3 cycles, then 1 with the data.
REQ-028 WAIT_CYCLES=3, SW with flush asserted in the 2nd wait cycle: the memory word is unchanged, and the FSM is in IDLE on the next cycle.
REQ-029 DEPTH=256, SW 0x1234 to 0x400, then LW 0x0: data is 0x1234 (wrap-around).
REQ-030 With MEM_MISALIGN_TRAP_EN defined, LH 0x11: misalign_memwb=1, regwrite_memwb=0, memdata_memwb=0; without the macro, the same access returns the halfword at 0x10.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-stage definitions: funct3 access encodings, the MEM FSM state type
// and byte-lane helpers used by mem_stage_pipe.
package riscv_pkg;

    typedef enum logic [2:0] {
        Funct3B  = 3'b000,
        Funct3H  = 3'b001,
        Funct3W  = 3'b010,
        Funct3D  = 3'b011,
        Funct3Bu = 3'b100,
        Funct3Hu = 3'b101
    } funct3_e;

    typedef enum logic {
        StIdle,
        StWait
    } mem_state_e;

    typedef enum logic [1:0] {
        SzB,
        SzH,
        SzW,
        SzD
    } acc_size_e;

    // D only exists on RV64; every unrecognised code behaves as a word access.
    function automatic acc_size_e decode_size(input logic [2:0] funct3, input logic is_rv64);
        case (funct3)
            Funct3B, Funct3Bu: return SzB;
            Funct3H, Funct3Hu: return SzH;
            Funct3D:           return is_rv64 ? SzD : SzW;
            default:           return SzW;
        endcase
    endfunction

    function automatic logic is_unsigned_load(input logic [2:0] funct3);
        return (funct3 == Funct3Bu) || (funct3 == Funct3Hu);
    endfunction

    // Byte-offset bits that must be zero for an aligned access of this size.
    function automatic logic [2:0] align_bits(input acc_size_e size);
        case (size)
            SzB:     return 3'b000;
            SzH:     return 3'b001;
            SzW:     return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input acc_size_e size);
        case (size)
            SzB:     return 8'h01;
            SzH:     return 8'h03;
            SzW:     return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_bytelane.sv
// Word-organised data memory with per-byte write enables, asynchronous read and a reset that
// clears the whole array.
module data_memory_bytelane #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [XLEN/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (be[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_stage_pipe.sv
// Pipelined MEM stage: branch resolution, byte-lane loads/stores with optional wait states, and
// the MEM/WB register. Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning.
module mem_stage_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] addr_exmem,
    input  logic [XLEN-1:0] wdata_exmem,
    input  logic [4:0]      rd_exmem,
    input  logic [2:0]      funct3_exmem,
    input  logic            branch_exmem,
    input  logic            zero_exmem,
    input  logic            memread_exmem,
    input  logic            memwrite_exmem,
    input  logic            mem2reg_exmem,
    input  logic            regwrite_exmem,
    input  logic            flush,
    output logic            pcsrc,
    output logic [XLEN-1:0] memdata_memwb,
    output logic [XLEN-1:0] addr_memwb,
    output logic [4:0]      rd_memwb,
    output logic            mem2reg_memwb,
    output logic            regwrite_memwb,
    output logic            valid_memwb
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            misalign_memwb
`endif
);

    localparam int unsigned OFFW    = $clog2(XLEN / 8);
    localparam int unsigned IDXW    = $clog2(DEPTH);
    localparam logic        IS_RV64 = (XLEN == 64);

    mem_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              access, complete, misaligned, we, sign;
    acc_size_e         size;
    logic [2:0]        off_raw, off;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   rdata, wdata_sh, shifted, load_data;
    int                nbits;

    assign pcsrc  = branch_exmem & zero_exmem & in_valid & ~flush;
    assign access = in_valid & (memread_exmem | memwrite_exmem);

    always_comb begin
        size              = decode_size(funct3_exmem, IS_RV64);
        off_raw           = '0;
        off_raw[OFFW-1:0] = addr_exmem[OFFW-1:0];
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = access && ((off_raw & align_bits(size)) != 3'b000);
        off        = off_raw;
`else
        misaligned = 1'b0;
        off        = off_raw & ~align_bits(size);
`endif
        be       = (XLEN/8)'(lane_mask(size) << off);
        wdata_sh = wdata_exmem << {off, 3'b000};
        shifted  = rdata >> {off, 3'b000};
        case (size)
            SzB:     begin nbits = 8;    sign = ~is_unsigned_load(funct3_exmem) & shifted[7];  end
            SzH:     begin nbits = 16;   sign = ~is_unsigned_load(funct3_exmem) & shifted[15]; end
            SzW:     begin nbits = 32;   sign = shifted[31];                                   end
            default: begin nbits = XLEN; sign = shifted[XLEN-1];                               end
        endcase
        load_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            load_data[i] = (i < nbits) ? shifted[i] : sign;
        end
    end

    // Flush overrides everything, including a completion in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = 1'b1;
        complete = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (access && !misaligned && (WAIT_CYCLES != 0)) begin
                        state_d  = StWait;
                        cnt_d    = 4'(WAIT_CYCLES);
                        in_ready = 1'b0;
                    end else begin
                        complete = in_valid;
                    end
                end
                StWait: begin
                    if (cnt_q <= 4'd1) begin
                        state_d  = StIdle;
                        cnt_d    = '0;
                        complete = in_valid;
                    end else begin
                        cnt_d    = cnt_q - 4'd1;
                        in_ready = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign we = complete & memwrite_exmem & ~misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    data_memory_bytelane #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .be    (be),
        .idx   (addr_exmem[IDXW+OFFW-1:OFFW]),
        .wdata (wdata_sh),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memdata_memwb  <= '0;
            addr_memwb     <= '0;
            rd_memwb       <= '0;
            mem2reg_memwb  <= 1'b0;
            regwrite_memwb <= 1'b0;
            valid_memwb    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_memwb <= 1'b0;
`endif
        end else if (complete) begin
            memdata_memwb  <= (memread_exmem && !misaligned) ? load_data : '0;
            addr_memwb     <= addr_exmem;
            rd_memwb       <= rd_exmem;
            mem2reg_memwb  <= mem2reg_exmem;
            regwrite_memwb <= regwrite_exmem & ~misaligned;
            valid_memwb    <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_memwb <= misaligned;
`endif
        end else begin
            memdata_memwb  <= '0;
            addr_memwb     <= '0;
            rd_memwb       <= '0;
            mem2reg_memwb  <= 1'b0;
            regwrite_memwb <= 1'b0;
            valid_memwb    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_memwb <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a zero-wait instance and a WAIT_CYCLES=3 instance share
// the EX/MEM inputs and are selected by their own in_valid.
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid0, in_valid3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        branch, zero, memread, memwrite, mem2reg, regwrite, flush;

    logic        in_ready0, pcsrc0, m2r0, rw0, valid0;
    logic [31:0] memdata0, addr_wb0;
    logic [4:0]  rd_wb0;
    logic        in_ready3, pcsrc3, m2r3, rw3, valid3;
    logic [31:0] memdata3, addr_wb3;
    logic [4:0]  rd_wb3;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mis0, mis3;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.XLEN(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .addr_exmem(addr), .wdata_exmem(wdata), .rd_exmem(rd), .funct3_exmem(f3),
        .branch_exmem(branch), .zero_exmem(zero), .memread_exmem(memread),
        .memwrite_exmem(memwrite), .mem2reg_exmem(mem2reg), .regwrite_exmem(regwrite),
        .flush(flush), .pcsrc(pcsrc0), .memdata_memwb(memdata0), .addr_memwb(addr_wb0),
        .rd_memwb(rd_wb0), .mem2reg_memwb(m2r0), .regwrite_memwb(rw0), .valid_memwb(valid0)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_memwb(mis0)
`endif
    );

    mem_stage_pipe #(.XLEN(32), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .addr_exmem(addr), .wdata_exmem(wdata), .rd_exmem(rd), .funct3_exmem(f3),
        .branch_exmem(branch), .zero_exmem(zero), .memread_exmem(memread),
        .memwrite_exmem(memwrite), .mem2reg_exmem(mem2reg), .regwrite_exmem(regwrite),
        .flush(flush), .pcsrc(pcsrc3), .memdata_memwb(memdata3), .addr_memwb(addr_wb3),
        .rd_memwb(rd_wb3), .mem2reg_memwb(m2r3), .regwrite_memwb(rw3), .valid_memwb(valid3)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_memwb(mis3)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        in_valid0 = 1'b0; in_valid3 = 1'b0;
        addr = '0; wdata = '0; rd = '0; f3 = 3'b010;
        branch = 1'b0; zero = 1'b0; memread = 1'b0; memwrite = 1'b0;
        mem2reg = 1'b0; regwrite = 1'b0; flush = 1'b0;
    endtask

    // Loads write back (mem2reg, regwrite); stores do not.
    task automatic set_mem(input logic ld, input logic st, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        memread = ld; memwrite = st; mem2reg = ld; regwrite = ld;
        f3 = f; addr = a; wdata = wd; rd = r;
    endtask

    // Drives one access on the zero-wait instance for one clock.
    task automatic op0(input logic ld, input logic st, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        set_mem(ld, st, f, a, wd, r);
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_idle();
        #12;
        vectors++;
        if (valid0 !== 1'b0 || rw0 !== 1'b0 || memdata0 !== 32'h0 || addr_wb0 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_memwb: valid=%b rw=%b data=%h addr=%h, want all 0",
                     valid0, rw0, memdata0, addr_wb0);
        end
        vectors++;
        if (in_ready0 !== 1'b1 || in_ready3 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b/%b want 1/1", in_ready0, in_ready3);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pcsrc;
        branch = 1'b1; zero = 1'b1; in_valid0 = 1'b1; #1;
        vectors++;
        if (pcsrc0 !== 1'b1) begin miscompares++; $display("FAIL pcsrc_taken: got %b want 1", pcsrc0); end
        zero = 1'b0; #1;
        vectors++;
        if (pcsrc0 !== 1'b0) begin miscompares++; $display("FAIL pcsrc_nz: got %b want 0", pcsrc0); end
        zero = 1'b1; flush = 1'b1; #1;
        vectors++;
        if (pcsrc0 !== 1'b0) begin miscompares++; $display("FAIL pcsrc_flush: got %b want 0", pcsrc0); end
        flush = 1'b0; in_valid0 = 1'b0; #1;
        vectors++;
        if (pcsrc0 !== 1'b0) begin miscompares++; $display("FAIL pcsrc_inv: got %b want 0", pcsrc0); end
        set_idle();
    endtask

    task automatic test_word;
        set_mem(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        in_valid0 = 1'b1; #1;
        vectors++;
        if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL sw_ready: got %b want 1", in_ready0); end
        tick(); in_valid0 = 1'b0;
        vectors++;
        if (valid0 !== 1'b1 || rw0 !== 1'b0 || memdata0 !== 32'h0 || addr_wb0 !== 32'h10) begin
            miscompares++;
            $display("FAIL sw_memwb: valid=%b rw=%b data=%h addr=%h want 1 0 0 10",
                     valid0, rw0, memdata0, addr_wb0);
        end
        op0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5);
        vectors++;
        if (memdata0 !== 32'hDEADBEEF || rd_wb0 !== 5'd5 || rw0 !== 1'b1 || m2r0 !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_word: data=%h rd=%0d rw=%b m2r=%b want deadbeef 5 1 1",
                     memdata0, rd_wb0, rw0, m2r0);
        end
    endtask

    task automatic test_byte_half;
        op0(1'b0, 1'b1, 3'b000, 32'h13, 32'h12345680, 5'd0);
        op0(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb: got %h want ffffff80", memdata0); end
        op0(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'h00000080) begin miscompares++; $display("FAIL lbu: got %h want 00000080", memdata0); end
        op0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'h80ADBEEF) begin miscompares++; $display("FAIL lw_after_sb: got %h want 80adbeef", memdata0); end
        op0(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'hFFFF80AD) begin miscompares++; $display("FAIL lh: got %h want ffff80ad", memdata0); end
        op0(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'h000080AD) begin miscompares++; $display("FAIL lhu: got %h want 000080ad", memdata0); end
        op0(1'b0, 1'b1, 3'b001, 32'h16, 32'hFFFF1234, 5'd0);
        op0(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'h12340000) begin miscompares++; $display("FAIL sh_upper: got %h want 12340000", memdata0); end
        op0(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'h80ADBEEF) begin miscompares++; $display("FAIL f3_011_as_w: got %h want 80adbeef", memdata0); end
        op0(1'b1, 1'b0, 3'b110, 32'h10, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'h80ADBEEF) begin miscompares++; $display("FAIL f3_110_as_w: got %h want 80adbeef", memdata0); end
    endtask

    task automatic test_wrap;
        op0(1'b0, 1'b1, 3'b010, 32'h400, 32'h00001234, 5'd0);
        op0(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd2);
        vectors++;
        if (memdata0 !== 32'h00001234) begin miscompares++; $display("FAIL wrap: got %h want 00001234", memdata0); end
    endtask

    task automatic test_misalign;
        op0(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 5'd3);
`ifdef MEM_MISALIGN_TRAP_EN
        vectors++;
        if (mis0 !== 1'b1 || rw0 !== 1'b0 || memdata0 !== 32'h0 || valid0 !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_trap: mis=%b rw=%b data=%h valid=%b want 1 0 0 1",
                     mis0, rw0, memdata0, valid0);
        end
        tick();
        vectors++;
        if (mis0 !== 1'b0) begin miscompares++; $display("FAIL misalign_pulse: got %b want 0", mis0); end
`else
        vectors++;
        if (memdata0 !== 32'hFFFFBEEF || rw0 !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_aligned: data=%h rw=%b want ffffbeef 1", memdata0, rw0);
        end
`endif
    endtask

    task automatic test_nonmem_flush;
        set_mem(1'b0, 1'b0, 3'b010, 32'h0000ABCD, 32'h0, 5'd9);
        regwrite = 1'b1;
        in_valid0 = 1'b1;
        tick(); in_valid0 = 1'b0;
        vectors++;
        if (valid0 !== 1'b1 || addr_wb0 !== 32'hABCD || memdata0 !== 32'h0 || rw0 !== 1'b1
            || m2r0 !== 1'b0 || rd_wb0 !== 5'd9) begin
            miscompares++;
            $display("FAIL alu_op: valid=%b addr=%h data=%h rw=%b m2r=%b rd=%0d",
                     valid0, addr_wb0, memdata0, rw0, m2r0, rd_wb0);
        end
        tick();
        vectors++;
        if (valid0 !== 1'b0) begin miscompares++; $display("FAIL bubble_idle: got %b want 0", valid0); end
        set_mem(1'b0, 1'b1, 3'b010, 32'h30, 32'h55555555, 5'd0);
        flush = 1'b1; in_valid0 = 1'b1;
        tick();
        flush = 1'b0; in_valid0 = 1'b0;
        vectors++;
        if (valid0 !== 1'b0) begin miscompares++; $display("FAIL flush_bubble: got %b want 0", valid0); end
        op0(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'h0) begin miscompares++; $display("FAIL flush_nowrite: got %h want 0", memdata0); end
    endtask

    task automatic test_wait_states;
        set_mem(1'b0, 1'b1, 3'b010, 32'h40, 32'h0BADCAFE, 5'd0);
        in_valid3 = 1'b1;
        repeat (4) tick();
        in_valid3 = 1'b0;
        set_mem(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd7);
        in_valid3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (in_ready3 !== 1'b0) begin miscompares++; $display("FAIL wait_ready_%0d: got %b want 0", k, in_ready3); end
            tick();
            vectors++;
            if (valid3 !== 1'b0) begin miscompares++; $display("FAIL wait_valid_%0d: got %b want 0", k, valid3); end
        end
        #1;
        vectors++;
        if (in_ready3 !== 1'b1) begin miscompares++; $display("FAIL wait_done_ready: got %b want 1", in_ready3); end
        tick();
        in_valid3 = 1'b0;
        vectors++;
        if (valid3 !== 1'b1 || memdata3 !== 32'h0BADCAFE || rd_wb3 !== 5'd7) begin
            miscompares++;
            $display("FAIL wait_load: valid=%b data=%h rd=%0d want 1 0badcafe 7", valid3, memdata3, rd_wb3);
        end
    endtask

    task automatic test_flush_in_wait;
        set_mem(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd0);
        in_valid3 = 1'b1;
        tick();
        tick();
        flush = 1'b1; #1;
        vectors++;
        if (in_ready3 !== 1'b1) begin miscompares++; $display("FAIL flush_wait_ready: got %b want 1", in_ready3); end
        tick();
        flush = 1'b0; in_valid3 = 1'b0;
        vectors++;
        if (valid3 !== 1'b0) begin miscompares++; $display("FAIL flush_wait_bubble: got %b want 0", valid3); end
        // A fresh load must see a full wait sequence, proving the FSM restarted from idle.
        set_mem(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd8);
        in_valid3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (in_ready3 !== 1'b0) begin miscompares++; $display("FAIL flush_idle_ready_%0d: got %b want 0", k, in_ready3); end
            tick();
        end
        tick();
        in_valid3 = 1'b0;
        vectors++;
        if (valid3 !== 1'b1 || memdata3 !== 32'h0BADCAFE) begin
            miscompares++;
            $display("FAIL flush_wait_nowrite: valid=%b data=%h want 1 0badcafe", valid3, memdata3);
        end
    endtask

    task automatic test_reset_clears_mem;
        rst_n = 1'b0; #2;
        vectors++;
        if (valid0 !== 1'b0 || valid3 !== 1'b0) begin
            miscompares++;
            $display("FAIL rerun_reset: got %b/%b want 0/0", valid0, valid3);
        end
        rst_n = 1'b1;
        tick();
        op0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
        vectors++;
        if (memdata0 !== 32'h0) begin miscompares++; $display("FAIL mem_cleared: got %h want 0", memdata0); end
    endtask

    initial begin
        test_reset();
        test_pcsrc();
        test_word();
        test_byte_half();
        test_wrap();
        test_misalign();
        test_nonmem_flush();
        test_wait_states();
        test_flush_in_wait();
        test_reset_clears_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
